// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: two-port arbiter and phase sequencer for a multiplexed SRAM bus (LE / OE_n / WE_n).
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority with port 0 first.
//
// state | meaning
// IDLE  | waiting for a request; the grant and its ready pulse happen here
// ADDR  | address on the pins, latch transparent
// HOLD  | latch closed, address still driven
// RD    | SRAM driving the bus; stays RD_WAIT+1 cycles
// SAMP  | bus turned back, read done pulse
// WDAT  | write data driven
// WSTB  | write strobe low
// WEND  | strobe released, data held, write done pulse
module sram_bus_arbiter #(
    parameter int W       = 8,
    parameter int RD_WAIT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic         req0_we,
    input  logic [W-1:0] req0_addr,
    input  logic [W-1:0] req0_wdata,
    output logic         req0_ready,
    output logic         req0_done,
    output logic [W-1:0] req0_rdata,
    input  logic         req1_valid,
    input  logic         req1_we,
    input  logic [W-1:0] req1_addr,
    input  logic [W-1:0] req1_wdata,
    output logic         req1_ready,
    output logic         req1_done,
    output logic [W-1:0] req1_rdata,
    output logic [W-1:0] bus_dout,
    output logic         bus_oe,
    input  logic [W-1:0] bus_din,
    output logic         latch_le,
    output logic         mem_oe_n,
    output logic         mem_we_n,
    output logic         busy
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_HOLD = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_SAMP = 3'd4;
    localparam logic [2:0] ST_WDAT = 3'd5;
    localparam logic [2:0] ST_WSTB = 3'd6;
    localparam logic [2:0] ST_WEND = 3'd7;

    localparam logic [2:0] RD_WAIT_CNT = 3'(RD_WAIT);

    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic [2:0]   rd_cnt;
    logic         rd_last;
    logic         cur_we;
    logic         cur_id;
    logic [W-1:0] cur_wdata;
    logic         gnt_any;
    logic         gnt_id;
    logic         sel_we;
    logic [W-1:0] sel_addr;
    logic [W-1:0] sel_wdata;
    logic         done_nxt;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic         last_gnt;
`endif

    // Requests are only looked at in IDLE; reset suppresses any grant in its cycle.
    always_comb begin
        gnt_any = (state == ST_IDLE) && !reset && (req0_valid || req1_valid);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_gnt;
        end else begin
            gnt_id = !req0_valid;
        end
`else
        gnt_id = !req0_valid;
`endif
    end

    assign req0_ready = gnt_any && !gnt_id;
    assign req1_ready = gnt_any && gnt_id;

    assign sel_we    = gnt_id ? req1_we    : req0_we;
    assign sel_addr  = gnt_id ? req1_addr  : req0_addr;
    assign sel_wdata = gnt_id ? req1_wdata : req0_wdata;

    assign rd_last  = (rd_cnt == 3'd0);
    assign done_nxt = (state_nxt == ST_SAMP) || (state_nxt == ST_WEND);
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (gnt_any) state_nxt = ST_ADDR;
            ST_ADDR: state_nxt = ST_HOLD;
            ST_HOLD: state_nxt = cur_we ? ST_WDAT : ST_RD;
            ST_RD:   if (rd_last) state_nxt = ST_SAMP;
            ST_SAMP: state_nxt = ST_IDLE;
            ST_WDAT: state_nxt = ST_WSTB;
            ST_WSTB: state_nxt = ST_WEND;
            ST_WEND: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pin registers are decoded from the next state so they line up with the state they belong to.
    // bus_oe and mem_oe_n share one decode, which keeps the bus turnaround contention-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rd_cnt     <= 3'd0;
            cur_we     <= 1'b0;
            cur_id     <= 1'b0;
            cur_wdata  <= '0;
            bus_dout   <= '0;
            bus_oe     <= 1'b1;
            latch_le   <= 1'b0;
            mem_oe_n   <= 1'b1;
            mem_we_n   <= 1'b1;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else begin
            state     <= state_nxt;
            latch_le  <= (state_nxt == ST_ADDR);
            mem_oe_n  <= (state_nxt != ST_RD);
            bus_oe    <= (state_nxt != ST_RD);
            mem_we_n  <= (state_nxt != ST_WSTB);
            req0_done <= done_nxt && !cur_id;
            req1_done <= done_nxt && cur_id;

            if (gnt_any) begin
                cur_we    <= sel_we;
                cur_id    <= gnt_id;
                cur_wdata <= sel_wdata;
                bus_dout  <= sel_addr;
            end else if (state_nxt == ST_WDAT) begin
                bus_dout  <= cur_wdata;
            end

            // Read wait timer: loaded on the way into RD, terminal count marks the sample cycle.
            if (state == ST_HOLD) begin
                rd_cnt <= RD_WAIT_CNT;
            end else if ((state == ST_RD) && !rd_last) begin
                rd_cnt <= rd_cnt - 3'd1;
            end

            if ((state == ST_RD) && rd_last) begin
                if (cur_id) begin
                    req1_rdata <= bus_din;
                end else begin
                    req0_rdata <= bus_din;
                end
            end
        end
    end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= 1'b1;
        end else if (gnt_any) begin
            last_gnt <= gnt_id;
        end
    end
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: SRAM + address-latch model on the pins, access scoreboard, vector table and corner sequences.
module tb_sram_bus_arbiter;

    localparam int RDW  = 1;
    localparam int HMAX = 32768;
    localparam int NVEC = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req0_we = 1'b0;
    logic [7:0] req0_addr = 8'h00, req0_wdata = 8'h00;
    logic       req1_valid = 1'b0, req1_we = 1'b0;
    logic [7:0] req1_addr = 8'h00, req1_wdata = 8'h00;
    logic       req0_ready, req0_done, req1_ready, req1_done;
    logic [7:0] req0_rdata, req1_rdata;
    logic [7:0] bus_dout, bus_din;
    logic       bus_oe, latch_le, mem_oe_n, mem_we_n, busy;

    // auxiliary instances for the RD_WAIT extremes
    logic       w0_valid = 1'b0, w7_valid = 1'b0;
    logic [7:0] w0_addr = 8'h00, w7_addr = 8'h00;
    logic       w0_ready, w0_done, w0_r1_ready, w0_r1_done, w0_bus_oe, w0_le, w0_oe_n, w0_we_n, w0_busy;
    logic       w7_ready, w7_done, w7_r1_ready, w7_r1_done, w7_bus_oe, w7_le, w7_oe_n, w7_we_n, w7_busy;
    logic [7:0] w0_rdata, w0_r1_rdata, w0_dout, w0_din, w7_rdata, w7_r1_rdata, w7_dout, w7_din;
    logic [7:0] la_w0 = 8'h00, la_w7 = 8'h00;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.W(8), .RD_WAIT(RDW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata),
        .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din),
        .latch_le(latch_le), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .busy(busy)
    );

    sram_bus_arbiter #(.W(8), .RD_WAIT(0)) u_w0 (
        .clk(clk), .reset(reset),
        .req0_valid(w0_valid), .req0_we(1'b0), .req0_addr(w0_addr), .req0_wdata(8'h00),
        .req0_ready(w0_ready), .req0_done(w0_done), .req0_rdata(w0_rdata),
        .req1_valid(1'b0), .req1_we(1'b0), .req1_addr(8'h00), .req1_wdata(8'h00),
        .req1_ready(w0_r1_ready), .req1_done(w0_r1_done), .req1_rdata(w0_r1_rdata),
        .bus_dout(w0_dout), .bus_oe(w0_bus_oe), .bus_din(w0_din),
        .latch_le(w0_le), .mem_oe_n(w0_oe_n), .mem_we_n(w0_we_n), .busy(w0_busy)
    );

    sram_bus_arbiter #(.W(8), .RD_WAIT(7)) u_w7 (
        .clk(clk), .reset(reset),
        .req0_valid(w7_valid), .req0_we(1'b0), .req0_addr(w7_addr), .req0_wdata(8'h00),
        .req0_ready(w7_ready), .req0_done(w7_done), .req0_rdata(w7_rdata),
        .req1_valid(1'b0), .req1_we(1'b0), .req1_addr(8'h00), .req1_wdata(8'h00),
        .req1_ready(w7_r1_ready), .req1_done(w7_r1_done), .req1_rdata(w7_r1_rdata),
        .bus_dout(w7_dout), .bus_oe(w7_bus_oe), .bus_din(w7_din),
        .latch_le(w7_le), .mem_oe_n(w7_oe_n), .mem_we_n(w7_we_n), .busy(w7_busy)
    );

    // SRAM and address latch models driven only by the pins
    logic [7:0] mem [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] la = 8'h00;

    always @(posedge clk) begin
        if (latch_le) la <= bus_dout;
        if (!mem_we_n) mem[la] <= bus_dout;
        if (w0_le) la_w0 <= w0_dout;
        if (w7_le) la_w7 <= w7_dout;
    end
    assign bus_din = mem_oe_n ? 8'h00 : mem[la];
    assign w0_din  = w0_oe_n ? 8'h00 : (la_w0 ^ 8'hC6);
    assign w7_din  = w7_oe_n ? 8'h00 : (la_w7 ^ 8'hC6);

    typedef struct {
        int         port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        int         acc;
    } sb_t;

    typedef struct {
        int         port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    sb_t        sb [$];
    int         gnt_log [$];
    int         n_chk = 0, n_pass = 0, inv_err = 0;
    int         cyc = 0, acc_total = 0, done_total = 0;
    int         acc_cnt [2];
    logic [6:0] hist_pins [0:HMAX-1];
    logic [7:0] hist_dout [0:HMAX-1];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        $display("FAIL %s: timed out waiting, required event never seen (cycle %0d)", name, cyc);
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic dn(input int p);
        return (p == 0) ? req0_done : req1_done;
    endfunction

    function automatic logic [7:0] rdata_of(input int p);
        return (p == 0) ? req0_rdata : req1_rdata;
    endfunction

    // bits: 0 le, 1 oe_n, 2 we_n, 3 bus_oe, 4 done0, 5 done1, 6 busy; MSB of result = cycle acc+1
    function automatic logic [4:0] trace(input int acc, input int b);
        logic [4:0] r;
        for (int k = 1; k <= 5; k++) r[5-k] = hist_pins[acc+k][b];
        return r;
    endfunction

    task automatic drive(input int p, input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic wait_ready(input int p, input int limit, output int acc);
        acc = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (rdy(p)) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) timeout_fail("accept_timeout");
    endtask

    task automatic wait_done(input int p, output int dc);
        dc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dn(p)) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) timeout_fail("done_timeout");
    endtask

    task automatic issue(input int p, input logic we, input logic [7:0] a, input logic [7:0] d, output int acc);
        @(posedge clk); #1;
        drive(p, 1'b1, we, a, d);
        wait_ready(p, 100, acc);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) timeout_fail("idle_timeout");
    endtask

    task automatic rand_port(input int p, input int n);
        int acc, dc;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(p, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            wait_ready(p, 300, acc);
            @(posedge clk); #1;
            drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
            wait_done(p, dc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    // monitor: pin history, invariants, scoreboard push on accept and pop on done
    always @(negedge clk) begin
        sb_t e;
        if (cyc < HMAX) begin
            hist_pins[cyc] = {busy, req1_done, req0_done, bus_oe, mem_we_n, mem_oe_n, latch_le};
            hist_dout[cyc] = bus_dout;
        end
        if (bus_oe !== mem_oe_n || (mem_oe_n === 1'b0 && mem_we_n === 1'b0)) inv_err++;
        if (w0_bus_oe !== w0_oe_n || w7_bus_oe !== w7_oe_n) inv_err++;
        if (reset) begin
            sb.delete();
        end else begin
            if (req0_ready && req1_ready) inv_err++;
            if (req0_done && req1_done) inv_err++;
            for (int p = 0; p < 2; p++) begin
                if (rdy(p)) begin
                    e.port = p;
                    e.we   = (p == 0) ? req0_we : req1_we;
                    e.addr = (p == 0) ? req0_addr : req1_addr;
                    e.acc  = cyc;
                    if (e.we) begin
                        e.data = (p == 0) ? req0_wdata : req1_wdata;
                        ref_mem[e.addr] = e.data;
                    end else begin
                        e.data = ref_mem[e.addr];
                    end
                    sb.push_back(e);
                    gnt_log.push_back(p);
                    acc_cnt[p]++;
                    acc_total++;
                end
            end
            if (req0_done || req1_done) begin
                done_total++;
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL done_unexpected: done0=%0b done1=%0b, required no done (cycle %0d)", req0_done, req1_done, cyc);
                end else begin
                    e = sb.pop_front();
                    check("sb_port", req1_done ? 32'd1 : 32'd0, e.port);
                    check("sb_latency", cyc - e.acc, e.we ? 5 : 4 + RDW);
                    if (!e.we) check("sb_rdata", rdata_of(e.port), e.data);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vec [NVEC];
        int   acc, acc1, dc, d0, d7, n0, n1, ok;
        int   acc_snap, done_snap;
        logic [7:0] saved, r0, r7;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h3C;
            ref_mem[i] = 8'(i) ^ 8'h3C;
        end
        mem[8'h10] = 8'h5A;
        ref_mem[8'h10] = 8'h5A;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;

        vec[0] = '{0, 1'b0, 8'h10, 8'h00, 8'h5A};
        vec[1] = '{1, 1'b1, 8'h22, 8'hC3, 8'h00};
        vec[2] = '{1, 1'b0, 8'h22, 8'h00, 8'hC3};
        vec[3] = '{0, 1'b1, 8'h80, 8'h00, 8'h00};
        vec[4] = '{0, 1'b0, 8'h80, 8'h00, 8'h00};
        vec[5] = '{1, 1'b1, 8'hFF, 8'hFF, 8'h00};
        vec[6] = '{0, 1'b0, 8'hFF, 8'h00, 8'hFF};
        vec[7] = '{1, 1'b0, 8'h10, 8'h00, 8'h5A};
        vec[8] = '{0, 1'b1, 8'h00, 8'hA5, 8'h00};
        vec[9] = '{1, 1'b0, 8'h00, 8'h00, 8'hA5};

        // reset values, with a request pending to show ready stays low under reset
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus_dout", bus_dout, 8'h00);
        check("rst_bus_oe", bus_oe, 1'b1);
        check("rst_latch_le", latch_le, 1'b0);
        check("rst_mem_oe_n", mem_oe_n, 1'b1);
        check("rst_mem_we_n", mem_we_n, 1'b1);
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_done", {req0_done, req1_done}, 2'b00);
        check("rst_rdata", {req0_rdata, req1_rdata}, 16'h0000);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);

        // table-driven accesses
        for (int i = 0; i < NVEC; i++) begin
            issue(vec[i].port, vec[i].we, vec[i].addr, vec[i].wdata, acc);
            wait_done(vec[i].port, dc);
            if (vec[i].we) check("vec_mem_write", mem[vec[i].addr], vec[i].wdata);
            else check("vec_rdata", rdata_of(vec[i].port), vec[i].exp_rdata);
            check("vec_latency", dc - acc, vec[i].we ? 5 : 4 + RDW);
            if (i == 0) begin
                @(posedge clk); #1;
                check("rd_trace_le", trace(acc, 0), 5'b10000);
                check("rd_trace_oe_n", trace(acc, 1), 5'b11001);
                check("rd_trace_bus_oe", trace(acc, 3), 5'b11001);
                check("rd_trace_we_n", trace(acc, 2), 5'b11111);
                check("rd_trace_done0", trace(acc, 4), 5'b00001);
                check("rd_trace_addr", hist_dout[acc+1], 8'h10);
            end
            if (i == 1) begin
                @(posedge clk); #1;
                check("wr_trace_le", trace(acc, 0), 5'b10000);
                check("wr_trace_we_n", trace(acc, 2), 5'b11101);
                check("wr_trace_oe_n", trace(acc, 1), 5'b11111);
                check("wr_trace_done1", trace(acc, 5), 5'b00001);
                check("wr_trace_addr", hist_dout[acc+1], 8'h22);
                check("wr_trace_data_c3", hist_dout[acc+3], 8'hC3);
                check("wr_trace_data_c4", hist_dout[acc+4], 8'hC3);
                check("wr_trace_data_c5", hist_dout[acc+5], 8'hC3);
            end
        end

        // request arriving while busy waits and is accepted right after done
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        wait_ready(0, 20, acc);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b1, 1'b1, 8'h55, 8'h11);
        wait_ready(1, 30, acc1);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        check("busy_wait_accept", acc1 - acc, 5 + RDW);
        wait_done(1, dc);
        check("busy_wait_mem", mem[8'h55], 8'h11);

        // valid withdrawn before ready: no access
        issue(1, 1'b1, 8'h60, 8'h99, acc);
        saved = mem[8'h44];
        n0 = acc_cnt[0];
        drive(0, 1'b1, 1'b1, 8'h44, 8'hEE);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_done(1, dc);
        repeat (3) @(posedge clk);
        check("drop_no_accept", acc_cnt[0], n0);
        check("drop_mem", mem[8'h44], saved);

        // reset during the write strobe
        issue(1, 1'b1, 8'h30, 8'h77, acc);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_wstb_we_low", mem_we_n, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_wstb_we_n", mem_we_n, 1'b1);
        check("rst_wstb_oe_n", mem_oe_n, 1'b1);
        check("rst_wstb_bus_oe", bus_oe, 1'b1);
        check("rst_wstb_busy", busy, 1'b0);
        n1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (req0_done || req1_done) n1++;
        end
        check("rst_wstb_no_done", n1, 0);

        // reset during write data phase: memory untouched
        saved = mem[8'h31];
        issue(1, 1'b1, 8'h31, 8'h88, acc);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ref_mem[8'h31] = saved;
        n1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (req0_done || req1_done) n1++;
        end
        check("rst_wdat_no_done", n1, 0);
        check("rst_wdat_mem", mem[8'h31], saved);

        // both ports requesting continuously
        @(posedge clk); #1;
        gnt_log.delete();
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h22, 8'h00);
        repeat (36) @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_idle();
        n0 = 0;
        n1 = 0;
        foreach (gnt_log[i]) begin
            if (gnt_log[i] == 0) n0++;
            else n1++;
        end
        check("arb_enough_grants", (n0 + n1) >= 5, 1'b1);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        ok = 1;
        for (int i = 1; i < gnt_log.size(); i++) if (gnt_log[i] == gnt_log[i-1]) ok = 0;
        check("arb_rr_alternate", ok, 1);
`else
        check("arb_fixed_p1_starved", n1, 0);
`endif

        // random contention mix
        acc_snap = acc_total;
        done_snap = done_total;
        fork
            rand_port(0, 500);
            rand_port(1, 500);
        join
        wait_idle();
        check("rand_accepts", acc_total - acc_snap, 1000);
        check("rand_done_eq_accept", done_total - done_snap, acc_total - acc_snap);
        check("rand_sb_empty", sb.size(), 0);
        check("invariants", inv_err, 0);

        // RD_WAIT extremes
        @(posedge clk); #1;
        w0_valid = 1'b1; w0_addr = 8'h3A;
        w7_valid = 1'b1; w7_addr = 8'h81;
        acc = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (w0_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) timeout_fail("rdw_accept_timeout");
        check("rdw7_accept", w7_ready, 1'b1);
        @(posedge clk); #1;
        w0_valid = 1'b0;
        w7_valid = 1'b0;
        d0 = -1; d7 = -1; r0 = 8'h00; r7 = 8'h00;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (w0_done && d0 < 0) begin d0 = cyc; r0 = w0_rdata; end
            if (w7_done && d7 < 0) begin d7 = cyc; r7 = w7_rdata; end
        end
        check("rdw0_latency", d0 - acc, 4);
        check("rdw7_latency", d7 - acc, 11);
        check("rdw0_rdata", r0, 8'hFC);
        check("rdw7_rdata", r7, 8'h47);
        check("invariants_final", inv_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
